// File: rtl/imm_chunk_serializer_pkg.sv
// imm_chunk_serializer_pkg: widths and FSM encoding shared by the immediate-chunk serializer
package imm_chunk_serializer_pkg;
    localparam int W_IN  = 16;
    localparam int W_IMM = 5;
    localparam int N_MAX = (W_IN + W_IMM - 1) / W_IMM;
    localparam int W_SR  = N_MAX * W_IMM;
    localparam int W_CNT = 3;
    typedef enum logic {IDLE, EMIT} state_e;
endpackage

// File: rtl/imm_chunk_serializer_count.sv
// imm_chunk_count: minimal number of 5-bit sign-extendable chunks needed to carry a 16-bit constant
module imm_chunk_count
    import imm_chunk_serializer_pkg::*;
(
    input  logic [W_IN-1:0]  value_i,
    output logic [W_CNT-1:0] n_o
);
    logic fit1, fit2, fit3;
    assign fit1 = (&value_i[15:4]) | ~(|value_i[15:4]);
    assign fit2 = (&value_i[15:9]) | ~(|value_i[15:9]);
    assign fit3 = value_i[15] == value_i[14];
    assign n_o  = fit1 ? 3'd1 : fit2 ? 3'd2 : fit3 ? 3'd3 : 3'd4;
endmodule

// File: rtl/imm_chunk_serializer.sv
// imm_chunk_serializer: splits a 16-bit signed constant into the minimal MSB-first run of 5-bit
// immediate chunks; the first chunk carries the sign and is sign-extended by the receiver.
module imm_chunk_serializer
    import imm_chunk_serializer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_IN-1:0]  in_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_IMM-1:0] out_chunk,
    output logic             out_first,
    output logic             out_last,
    output logic [W_CNT-1:0] out_count
);
    state_e           state_q, state_d;
    logic [W_SR-1:0]  sr_q, sr_d;
    logic [W_CNT-1:0] rem_q, rem_d, cnt_q, cnt_d, n;
    logic             first_q, first_d;
    logic [4:0]       shamt;
    logic [W_SR-1:0]  ext;

    imm_chunk_count u_count (.value_i(in_value), .n_o(n));

    // left-align so the sign-carrying group sits in the top chunk slot
    assign ext   = {{(W_SR-W_IN){in_value[W_IN-1]}}, in_value};
    assign shamt = 5'(W_IMM * (N_MAX - int'(n)));

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        if (state_q == IDLE) begin
            if (in_valid) begin
                state_d = EMIT;
                sr_d    = ext << shamt;
                rem_d   = n;
                cnt_d   = n;
                first_d = 1'b1;
            end
        end else if (out_ready) begin
            first_d = 1'b0;
            state_d = (rem_q == 3'd1) ? IDLE : EMIT;
            sr_d    = (rem_q == 3'd1) ? sr_q : sr_q << W_IMM;
            rem_d   = (rem_q == 3'd1) ? rem_q : rem_q - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == EMIT;
    assign out_chunk = sr_q[W_SR-1 -: W_IMM];
    assign out_first = first_q;
    assign out_last  = (state_q == EMIT) && (rem_q == 3'd1);
    assign out_count = cnt_q;
endmodule

// File: tb/tb_imm_chunk_serializer.sv
// tb_imm_chunk_serializer: directed bursts with a reconstructing scoreboard, async-reset check
// and an exhaustive sweep of the chunk-count sub-module against a range-based model.
module tb_imm_chunk_serializer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_first, out_last;
    logic [15:0] in_value;
    logic [4:0]  out_chunk;
    logic [2:0]  out_count;
    logic [15:0] sw;
    logic [2:0]  sw_n;
    logic [4:0]  got [4];
    logic [15:0] acc;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    imm_chunk_serializer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
        .out_valid(out_valid), .out_ready(out_ready), .out_chunk(out_chunk), .out_first(out_first),
        .out_last(out_last), .out_count(out_count)
    );

    imm_chunk_count u_cnt (.value_i(sw), .n_o(sw_n));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // smallest n whose 5n-bit signed range contains v
    function automatic int model_n(input logic [15:0] v);
        int s = int'($signed(v));
        for (int n = 1; n < 4; n++)
            if (s >= -(1 << (5*n-1)) && s < (1 << (5*n-1))) return n;
        return 4;
    endfunction

    task automatic burst(input logic [15:0] v, input int stall_at, input int stall_n);
        int          n;
        logic [19:0] ext;
        logic [4:0]  c;
        n   = model_n(v);
        ext = {{4{v[15]}}, v};
        @(negedge clk);
        chk("idle_ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_value = v;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("latency1_valid", 32'(out_valid), 1);
        for (int k = 0; k < n; k++) begin
            c = out_chunk;
            got[k] = c;
            chk("valid", 32'(out_valid), 1);
            chk("busy_ready", 32'(in_ready), 0);
            chk("first", 32'(out_first), 32'(k == 0));
            chk("last", 32'(out_last), 32'(k == n-1));
            chk("count", 32'(out_count), 32'(n));
            chk("chunk", 32'(c), 32'((ext >> (5*(n-1-k))) & 20'h1f));
            if (k == stall_at) begin
                for (int s = 0; s < stall_n; s++) begin
                    @(negedge clk);
                    chk("stall_chunk", 32'(out_chunk), 32'(c));
                    chk("stall_valid", 32'(out_valid), 1);
                    chk("stall_ready", 32'(in_ready), 0);
                    chk("stall_fl", 32'({out_first, out_last}), 32'({k == 0, k == n-1}));
                end
            end
            acc = (k == 0) ? {{11{c[4]}}, c} : {acc[10:0], c};
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        chk("done_valid", 32'(out_valid), 0);
        chk("done_ready", 32'(in_ready), 1);
        chk("rebuild", 32'(acc), 32'(v));
    endtask

    initial begin
        int bad;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_value = '0;
        out_ready = 1'b0;
        sw = '0;
        #1;
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_outs", 32'({out_chunk, out_first, out_last, out_count}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        burst(16'h0004, -1, 0);
        chk("t1_c0", 32'(got[0]), 32'b00100);
        burst(16'hFFF8, -1, 0);
        chk("t2_c0", 32'(got[0]), 32'b11000);
        chk("t2_sext", 32'(acc), 32'hFFF8);
        burst(16'h0010, -1, 0);
        chk("t3_c", 32'({got[0], got[1]}), 32'({5'b00000, 5'b10000}));
        burst(16'h8000, -1, 0);
        chk("t4_c", 32'({got[0], got[1], got[2], got[3]}), 32'({5'b11111, 15'd0}));
        burst(16'h7FFF, 1, 3);
        chk("t5_c", 32'({got[0], got[1], got[2], got[3]}), 32'({5'b00000, 15'h7FFF}));
        burst(16'h000F, -1, 0);
        chk("b_000f_n1", 32'(model_n(16'h000F)), 1);
        burst(16'hFFF0, 0, 2);
        burst(16'hFFEF, -1, 0);
        chk("b_ffef_c", 32'({got[0], got[1]}), 32'({5'b11111, 5'b01111}));

        // async reset during chunk 2 of 0x8000
        @(negedge clk);
        in_valid = 1'b1;
        in_value = 16'h8000;
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("r_mid_valid", 32'(out_valid), 1);
        chk("r_mid_last", 32'(out_last), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("r_valid", 32'(out_valid), 0);
        chk("r_ready", 32'(in_ready), 1);
        chk("r_outs", 32'({out_chunk, out_first, out_last, out_count}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        burst(16'h0004, -1, 0);
        chk("r_after_c0", 32'(got[0]), 32'b00100);

        for (int i = 0; i < 120; i++)
            burst(16'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 2)));

        bad = 0;
        for (int v = 0; v < 65536; v++) begin
            sw = 16'(v);
            #1;
            if (32'(sw_n) != 32'(model_n(sw))) bad++;
        end
        chk("sweep_min_n", 32'(bad), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
